// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation and
// FSM state encodings, default operand width, and small op-decode helpers.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } mdu_state_e;

    // Upper op bit selects divide over multiply.
    function automatic logic op_is_div(input mdu_op_e op);
        return op[1];
    endfunction

    // MULT and DIV (op[0]==0) treat operands as two's complement.
    function automatic logic op_is_signed(input mdu_op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Execute-stage handshake and HI/LO bus between the pipeline and the MDU.
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             we_hi;
    logic             we_lo;
    logic [WIDTH-1:0] wd;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, we_hi, we_lo, wd,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, we_hi, we_lo, wd,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// followed by one sign-correction cycle; latency is fixed for every op.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic      clk,
    input  logic      reset,
    mdu_iter_if.slave bus
);

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

    mdu_state_e       r_state;
    mdu_state_e       w_next;
    logic [CW-1:0]    r_cnt;
    mdu_op_e          r_op;
    logic             r_neg_q;    // negate product / quotient at FIX
    logic             r_neg_r;    // negate remainder at FIX (dividend negative)
    logic             r_b_zero;   // divide by zero
    logic [WIDTH-1:0] r_a_raw;    // raw dividend, returned in HI on divide by zero
    logic [WIDTH-1:0] r_opnd;     // multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0] r_ph;       // partial product high / partial remainder
    logic [WIDTH-1:0] r_pl;       // multiplier bits / quotient bits
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;

    mdu_op_e          w_op;
    logic             w_signed;
    logic             w_div;
    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_ph_nxt;
    logic [WIDTH-1:0] w_pl_nxt;

    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    assign w_op     = mdu_op_e'(bus.op);
    assign w_signed = op_is_signed(w_op);
    assign w_div    = op_is_div(w_op);
    assign w_neg_a  = w_signed & bus.a[WIDTH-1];
    assign w_neg_b  = w_signed & bus.b[WIDTH-1];
    assign w_mag_a  = w_neg_a ? -bus.a : bus.a;
    assign w_mag_b  = w_neg_b ? -bus.b : bus.b;

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: IDLE -> CALC on start, CALC -> FIX after WIDTH steps.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next = CALC;
                end else begin
                    w_next = IDLE;
                end
            end
            CALC: begin
                if (r_cnt == LAST_CNT) begin
                    w_next = FIX;
                end else begin
                    w_next = CALC;
                end
            end
            FIX:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // One radix-2 step: conditional add-and-shift or trial-subtract-and-shift.
    always_comb begin
        w_sum    = {(WIDTH+1){1'b0}};
        w_shift  = {r_ph, r_pl[WIDTH-1]};
        w_diff   = w_shift[WIDTH-1:0] - r_opnd;
        w_ph_nxt = r_ph;
        w_pl_nxt = r_pl;
        if (r_op[1]) begin
            if (w_shift >= {1'b0, r_opnd}) begin
                w_ph_nxt = w_diff;
                w_pl_nxt = {r_pl[WIDTH-2:0], 1'b1};
            end else begin
                w_ph_nxt = w_shift[WIDTH-1:0];
                w_pl_nxt = {r_pl[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (r_pl[0]) begin
                w_sum = {1'b0, r_ph} + {1'b0, r_opnd};
            end else begin
                w_sum = {1'b0, r_ph};
            end
            w_ph_nxt = w_sum[WIDTH:1];
            w_pl_nxt = {w_sum[0], r_pl[WIDTH-1:1]};
        end
    end

    // Sign correction and divide-by-zero override of the final HI/LO values.
    always_comb begin
        w_prod     = {r_ph, r_pl};
        w_prod_fix = w_prod;
        w_fix_hi   = r_hi;
        w_fix_lo   = r_lo;
        if (r_op[1]) begin
            if (r_b_zero) begin
                w_fix_lo = {WIDTH{1'b1}};
                w_fix_hi = r_a_raw;
            end else begin
                w_fix_lo = r_neg_q ? -r_pl : r_pl;
                w_fix_hi = r_neg_r ? -r_ph : r_ph;
            end
        end else begin
            w_prod_fix = r_neg_q ? -w_prod : w_prod;
            w_fix_hi   = w_prod_fix[2*WIDTH-1:WIDTH];
            w_fix_lo   = w_prod_fix[WIDTH-1:0];
        end
    end

    // Datapath: operand capture, iteration, MTHI/MTLO writes and HI/LO commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= {CW{1'b0}};
            r_op     <= MDU_MULT;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_b_zero <= 1'b0;
            r_a_raw  <= {WIDTH{1'b0}};
            r_opnd   <= {WIDTH{1'b0}};
            r_ph     <= {WIDTH{1'b0}};
            r_pl     <= {WIDTH{1'b0}};
            r_hi     <= {WIDTH{1'b0}};
            r_lo     <= {WIDTH{1'b0}};
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_busy <= (w_next != IDLE);
            r_done <= (r_state == FIX);
            case (r_state)
                IDLE: begin
                    if (bus.we_hi) begin
                        r_hi <= bus.wd;
                    end else begin
                        r_hi <= r_hi;
                    end
                    if (bus.we_lo) begin
                        r_lo <= bus.wd;
                    end else begin
                        r_lo <= r_lo;
                    end
                    if (bus.start) begin
                        r_op     <= w_op;
                        r_neg_q  <= w_neg_a ^ w_neg_b;
                        r_neg_r  <= w_div & w_neg_a;
                        r_b_zero <= w_div & (bus.b == {WIDTH{1'b0}});
                        r_a_raw  <= bus.a;
                        r_opnd   <= w_div ? w_mag_b : w_mag_a;
                        r_pl     <= w_div ? w_mag_a : w_mag_b;
                        r_ph     <= {WIDTH{1'b0}};
                        r_cnt    <= {CW{1'b0}};
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                CALC: begin
                    r_ph  <= w_ph_nxt;
                    r_pl  <= w_pl_nxt;
                    r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                end
                FIX: begin
                    r_hi <= w_fix_hi;
                    r_lo <= w_fix_lo;
                end
                default: begin
                    r_cnt <= {CW{1'b0}};
                end
            endcase
        end
    end

endmodule
